msx_slot_sequencer: RTL and testbench
=====================================

# msx_slot_sequencer

Parametrised successor of the MSX slot decoder. Holds per-primary-slot subslot (expander) registers, resolves each CPU memory cycle into a layout-table index through one registered lookup stage, and then sequences a single request/acknowledge transaction to the RAM back end. The CPU is stretched with `wait_n` until the transaction completes. It sits between the Z80 bus and the SDRAM/BRAM arbiter, replacing combinational slot decode with a pipelined, handshaked path.

## Interface
Parameters:
- `SLOTS`, 4: number of primary slots (power of two, 2..8).
- `ADDR_W`, 27: RAM address width.
- `SIZE_W`, 16: layout size field width, in units of 16 kB.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `cpu_addr` in 16: CPU address.
- `cpu_dout` in 8: CPU write data.
- `cpu_mreq`, `cpu_rd`, `cpu_wr` in 1: CPU strobes, level, held for the whole cycle.
- `active_slot` in $clog2(SLOTS): current primary slot.
- `expander_en` in SLOTS: per-slot expander present.
- `exp_dout` out 8: expander readback, 8'hFF when not selected.
- `layout_idx` out $clog2(SLOTS)+4: registered layout index {slot, subslot, block}.
- `layout_base` in ADDR_W: base address of the entry, valid one cycle after `layout_idx`.
- `layout_size` in SIZE_W: size of the entry.
- `layout_ro` in 1: entry is read-only.
- `layout_valid` in 1: entry is mapped.
- `mem_req` out 1: request to the RAM back end.
- `mem_we` out 1: write request.
- `mem_addr` out ADDR_W: RAM address.
- `mem_din` out 8: RAM write data.
- `mem_ack` in 1: one-cycle completion pulse.
- `wait_n` out 1: CPU wait, low means stretch.
- `unmapped` out 1: current cycle is not backed by RAM.

## Operation
- Expander register `sub[s]` (8 bits) per slot.
  - Selected when `cpu_addr==16'hFFFF & expander_en[active_slot] & cpu_mreq`.
  - Write: `sub[active_slot] <= cpu_dout`.
  - Read: `exp_dout = ~sub[active_slot]`, and no RAM request is made.
- Subslot = `sub[active_slot][2*block +: 2]` with `block = cpu_addr[15:14]`. It is 0 when the expander is disabled.
- FSM states: IDLE, LOOKUP, ACCESS, HOLD.
  - IDLE → LOOKUP on rising `cpu_mreq & (cpu_rd|cpu_wr)`. Latch the address, data and direction; register `layout_idx`.
  - LOOKUP → ACCESS if `layout_valid` and not an expander access and the write is not suppressed. Otherwise → HOLD with `unmapped=1`.
  - ACCESS: `mem_req=1`. Stay in ACCESS until `mem_ack`, then → HOLD.
  - HOLD → IDLE when `cpu_mreq=0`.
- Address: `mem_addr = layout_base + ({block,addr[13:0]} & ((layout_size<<14)-1))`. Width is ADDR_W, wrap modulo 2^ADDR_W, and a zero size yields offset 0.
- `mem_we` = latched write. `mem_din` = latched `cpu_dout`.

## Timing
- Reset values: `sub[*]=0`; state IDLE; `mem_req=0`; `mem_we=0`; `mem_addr=0`; `mem_din=0`; `wait_n=1`; `unmapped=0`; `layout_idx=0`.
- `wait_n` drops combinationally on the strobe edge in IDLE. It stays low through LOOKUP and ACCESS and rises in the HOLD entry cycle.
- Latency: strobe → `mem_req` is 2 cycles. `mem_ack` → `wait_n` high is 1 cycle.
- An expander or unmapped access costs 2 cycles of wait.
- `mem_req`, `mem_we`, `mem_addr` and `mem_din` are stable from ACCESS entry until the cycle after `mem_ack`.
- `mem_ack` outside ACCESS is ignored.
- An expander write takes effect at LOOKUP.
- A new strobe arriving in HOLD before `cpu_mreq` falls is ignored.
- `reset_n` low mid-ACCESS forces IDLE next cycle and drops `mem_req`. The back end must tolerate an abandoned request.

## Configuration
- `MSX_SLOT_RO_EN` defined:
  - A write to an entry with `layout_ro=1` skips ACCESS and goes LOOKUP → HOLD.
  - `unmapped` stays 0, and the write is silently dropped.
- `MSX_SLOT_RO_EN` undefined:
  - `layout_ro` is ignored and all writes reach the back end.

## Structure
- Shared package `MSX`:
  - FSM state enum `slot_seq_state_t`.
  - Constant `EXPANDER_ADDR = 16'hFFFF`.
  - Constant `BLOCK_SHIFT = 14`.
- One sub-module, `slot_expander_regs`: the SLOTS×8 register bank with inverted readback and subslot extraction.
- Address arithmetic and the FSM live in the top module.

## Test plan
1. Reset, then read 0x4000 in slot 1 with expander disabled.
   - Required: `layout_idx = {1,0,1}` and `mem_req` at cycle 2.
   - Stimulus: base 0x10000, size 2. Required: `mem_addr = 0x14000`.
   - Stimulus: ack at cycle 4. Required: `wait_n` high at cycle 5.
2. Slot 3 with expander enabled:
   - Write 0xE4 to 0xFFFF. Required: no `mem_req`.
   - Read 0xFFFF. Required: `exp_dout = 0x1B`.
   - Read 0x8000. Required: `layout_idx = {3,2,2}`.
3. Entry with `layout_valid=0`: read. Required: `unmapped=1`, no `mem_req`, `wait_n` back high after 2 cycles.
4. With `MSX_SLOT_RO_EN`: write to a RO entry. Required: no `mem_req`. Without the macro: `mem_req` with `mem_we=1`.
5. Size 1, base 0x20000, read 0xC123. Required: `mem_addr = 0x20123` (mask wrap).
6. Deassert `reset_n` during ACCESS. Required: next cycle `mem_req=0`, `wait_n=1`, `sub[*]=0`.

Source files
------------

// File: rtl/msx_slot_sequencer_pkg.sv
// rtl/msx_slot_sequencer_pkg.sv - shared types and constants for the MSX slot sequencer
package MSX;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } slot_seq_state_t;

    localparam logic [15:0] EXPANDER_ADDR = 16'hFFFF;
    localparam int          BLOCK_SHIFT   = 14;

endpackage

// File: rtl/msx_slot_sequencer_if.sv
// rtl/msx_slot_sequencer_if.sv - request/acknowledge bus between sequencer and RAM back end
interface msx_slot_sequencer_if #(
    parameter int ADDR_W = 27
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_din,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_din,
        output mem_ack
    );
endinterface

// File: rtl/msx_slot_sequencer_expander_regs.sv
// rtl/msx_slot_sequencer_expander_regs.sv - per-slot subslot registers with inverted readback
module slot_expander_regs #(
    parameter int SLOTS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(SLOTS)-1:0] wr_slot,
    input  logic [7:0]               wr_data,
    input  logic [$clog2(SLOTS)-1:0] rd_slot,
    input  logic                     rd_present,
    input  logic [1:0]               block,
    output logic [7:0]               rd_inv,
    output logic [1:0]               subslot
);
    logic [7:0] sub [SLOTS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                sub[i] <= 8'h00;
            end
        end else if (wr_en) begin
            sub[wr_slot] <= wr_data;
        end
    end

    assign rd_inv  = ~sub[rd_slot];
    // Each 16 kB block owns a 2-bit field; slots without an expander see subslot 0.
    assign subslot = rd_present ? sub[rd_slot][{block, 1'b0} +: 2] : 2'b00;

endmodule

// File: rtl/msx_slot_sequencer.sv
// rtl/msx_slot_sequencer.sv - pipelined MSX slot decode and RAM request sequencer; MSX_SLOT_RO_EN drops writes to read-only entries
module msx_slot_sequencer
    import MSX::*;
#(
    parameter int SLOTS  = 4,
    parameter int ADDR_W = 27,
    parameter int SIZE_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [15:0]                cpu_addr,
    input  logic [7:0]                 cpu_dout,
    input  logic                       cpu_mreq,
    input  logic                       cpu_rd,
    input  logic                       cpu_wr,
    input  logic [$clog2(SLOTS)-1:0]   active_slot,
    input  logic [SLOTS-1:0]           expander_en,
    output logic [7:0]                 exp_dout,
    output logic [$clog2(SLOTS)+3:0]   layout_idx,
    input  logic [ADDR_W-1:0]          layout_base,
    input  logic [SIZE_W-1:0]          layout_size,
    input  logic                       layout_ro,
    input  logic                       layout_valid,
    msx_slot_sequencer_if.master       mem,
    output logic                       wait_n,
    output logic                       unmapped
);
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    slot_seq_state_t state, state_nxt;

    logic        strobe, strobe_q, start, exp_sel;
    logic [7:0]  exp_rd;
    logic [1:0]  subslot;
    logic [1:0]  blk_q;
    logic [13:0] off_q;
    logic [7:0]  din_q;
    logic        wr_q, exp_q, unm_q;
    logic        ro_block, go_access;

    logic [ADDR_W-1:0] size_ext, mask, offset, addr_calc;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [7:0]        mem_din_q;

    assign strobe  = cpu_mreq & (cpu_rd | cpu_wr);
    assign exp_sel = (cpu_addr == EXPANDER_ADDR) & expander_en[active_slot] & cpu_mreq;
    // Gated by reset_n so a strobe held across reset never starts a cycle.
    assign start   = reset_n & (state == ST_IDLE) & strobe & ~strobe_q;

    always_ff @(posedge clk) begin
        strobe_q <= strobe;
    end

    slot_expander_regs #(.SLOTS(SLOTS)) u_exp (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (start & exp_sel & cpu_wr),
        .wr_slot    (active_slot),
        .wr_data    (cpu_dout),
        .rd_slot    (active_slot),
        .rd_present (expander_en[active_slot]),
        .block      (cpu_addr[15:14]),
        .rd_inv     (exp_rd),
        .subslot    (subslot)
    );

    assign exp_dout = exp_sel ? exp_rd : 8'hFF;

`ifdef MSX_SLOT_RO_EN
    assign ro_block = wr_q & layout_ro;
`else
    assign ro_block = 1'b0;
`endif

    assign go_access = layout_valid & ~exp_q & ~ro_block;

    // A zero size maps the whole entry onto its base address.
    always_comb begin
        size_ext  = ADDR_W'(layout_size);
        mask      = (layout_size == '0) ? '0 : ((size_ext << BLOCK_SHIFT) - ONE);
        offset    = ADDR_W'({blk_q, off_q}) & mask;
        addr_calc = layout_base + offset;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOOKUP;
            ST_LOOKUP: state_nxt = go_access ? ST_ACCESS : ST_HOLD;
            ST_ACCESS: if (mem.mem_ack) state_nxt = ST_HOLD;
            ST_HOLD:   if (!cpu_mreq) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_n      = 1'b1;
        unmapped    = 1'b0;
        mem.mem_req = 1'b0;
        case (state)
            ST_IDLE:   wait_n = ~start;
            ST_LOOKUP: wait_n = 1'b0;
            ST_ACCESS: begin
                wait_n      = 1'b0;
                mem.mem_req = 1'b1;
            end
            ST_HOLD:   unmapped = unm_q;
            default:   wait_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blk_q      <= 2'b00;
            off_q      <= 14'h0;
            din_q      <= 8'h00;
            wr_q       <= 1'b0;
            exp_q      <= 1'b0;
            unm_q      <= 1'b0;
            layout_idx <= '0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= 8'h00;
        end else begin
            if (start) begin
                blk_q      <= cpu_addr[15:14];
                off_q      <= cpu_addr[13:0];
                din_q      <= cpu_dout;
                wr_q       <= cpu_wr;
                exp_q      <= exp_sel;
                layout_idx <= {active_slot, subslot, cpu_addr[15:14]};
            end
            if (state == ST_LOOKUP) begin
                unm_q <= exp_q | ~layout_valid;
                if (go_access) begin
                    mem_addr_q <= addr_calc;
                    mem_we_q   <= wr_q;
                    mem_din_q  <= din_q;
                end
            end
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.mem_din  = mem_din_q;

endmodule

// File: tb/tb_msx_slot_sequencer.sv
// tb/tb_msx_slot_sequencer.sv - directed vector bench for msx_slot_sequencer
module tb_msx_slot_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_mreq, cpu_rd, cpu_wr;
    logic [1:0]  active_slot;
    logic [3:0]  expander_en;
    logic [7:0]  exp_dout;
    logic [5:0]  layout_idx;
    logic [26:0] layout_base;
    logic [15:0] layout_size;
    logic        layout_ro, layout_valid;
    logic        wait_n, unmapped;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    msx_slot_sequencer_if #(.ADDR_W(27)) mem_bus ();

    msx_slot_sequencer #(.SLOTS(4), .ADDR_W(27), .SIZE_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_addr     (cpu_addr),
        .cpu_dout     (cpu_dout),
        .cpu_mreq     (cpu_mreq),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .active_slot  (active_slot),
        .expander_en  (expander_en),
        .exp_dout     (exp_dout),
        .layout_idx   (layout_idx),
        .layout_base  (layout_base),
        .layout_size  (layout_size),
        .layout_ro    (layout_ro),
        .layout_valid (layout_valid),
        .mem          (mem_bus),
        .wait_n       (wait_n),
        .unmapped     (unmapped)
    );

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  slot;
        logic [3:0]  en;
        logic        wr;
        logic [7:0]  dout;
        logic [26:0] base;
        logic [15:0] size;
        logic        valid;
        logic        ro;
        logic [7:0]  x_exp;
        logic [5:0]  x_idx;
        logic        x_req;
        logic [26:0] x_addr;
        logic        x_we;
        logic        x_unm;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] addr, input logic [1:0] slot, input logic [3:0] en,
                         input logic wr, input logic [7:0] dout, input logic [26:0] base,
                         input logic [15:0] size, input logic valid, input logic ro);
        cpu_addr     = addr;
        active_slot  = slot;
        expander_en  = en;
        cpu_dout     = dout;
        layout_base  = base;
        layout_size  = size;
        layout_valid = valid;
        layout_ro    = ro;
        cpu_mreq     = 1'b1;
        cpu_wr       = wr;
        cpu_rd       = ~wr;
    endtask

    task automatic release_bus();
        cpu_mreq = 1'b0;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        next_cycle();
        drive(v.addr, v.slot, v.en, v.wr, v.dout, v.base, v.size, v.valid, v.ro);
        @(negedge clk);
        chk($sformatf("v%0d c0 wait_n", i), 32'(wait_n), 32'd0);
        chk($sformatf("v%0d c0 exp_dout", i), 32'(exp_dout), 32'(v.x_exp));
        next_cycle();
        @(negedge clk);
        chk($sformatf("v%0d c1 layout_idx", i), 32'(layout_idx), 32'(v.x_idx));
        chk($sformatf("v%0d c1 mem_req", i), 32'(mem_bus.mem_req), 32'd0);
        next_cycle();
        @(negedge clk);
        chk($sformatf("v%0d c2 mem_req", i), 32'(mem_bus.mem_req), 32'(v.x_req));
        if (v.x_req) begin
            chk($sformatf("v%0d c2 mem_addr", i), 32'(mem_bus.mem_addr), 32'(v.x_addr));
            chk($sformatf("v%0d c2 mem_we", i), 32'(mem_bus.mem_we), 32'(v.x_we));
            if (v.x_we) chk($sformatf("v%0d c2 mem_din", i), 32'(mem_bus.mem_din), 32'(v.dout));
            chk($sformatf("v%0d c2 wait_n", i), 32'(wait_n), 32'd0);
            next_cycle();
            next_cycle();
            mem_bus.mem_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d c4 mem_addr", i), 32'(mem_bus.mem_addr), 32'(v.x_addr));
            next_cycle();
            mem_bus.mem_ack = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d c5 wait_n", i), 32'(wait_n), 32'd1);
            chk($sformatf("v%0d c5 mem_req", i), 32'(mem_bus.mem_req), 32'd0);
        end else begin
            chk($sformatf("v%0d c2 wait_n", i), 32'(wait_n), 32'd1);
            chk($sformatf("v%0d c2 unmapped", i), 32'(unmapped), 32'(v.x_unm));
        end
        next_cycle();
        release_bus();
        next_cycle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          addr      slt en     wr dout   base          size   v  ro  x_exp  x_idx  req addr          we unm
        vecs[0] = '{16'h4000, 2'd1, 4'h0, 0, 8'h00, 27'h0010000, 16'd2, 1, 0, 8'hFF, 6'h11, 1, 27'h0014000, 0, 0};
        vecs[1] = '{16'hFFFF, 2'd3, 4'h8, 1, 8'hE4, 27'h0000000, 16'd2, 1, 0, 8'hFF, 6'h33, 0, 27'h0000000, 0, 1};
        vecs[2] = '{16'hFFFF, 2'd3, 4'h8, 0, 8'h00, 27'h0000000, 16'd2, 1, 0, 8'h1B, 6'h3F, 0, 27'h0000000, 0, 1};
        vecs[3] = '{16'h8000, 2'd3, 4'h8, 0, 8'h00, 27'h0000000, 16'd4, 1, 0, 8'hFF, 6'h3A, 1, 27'h0008000, 0, 0};
        vecs[4] = '{16'h2000, 2'd0, 4'h0, 0, 8'h00, 27'h0030000, 16'd2, 0, 0, 8'hFF, 6'h00, 0, 27'h0000000, 0, 1};
`ifdef MSX_SLOT_RO_EN
        vecs[5] = '{16'h4555, 2'd2, 4'h0, 1, 8'h5A, 27'h0040000, 16'd2, 1, 1, 8'hFF, 6'h21, 0, 27'h0000000, 0, 0};
`else
        vecs[5] = '{16'h4555, 2'd2, 4'h0, 1, 8'h5A, 27'h0040000, 16'd2, 1, 1, 8'hFF, 6'h21, 1, 27'h0044555, 1, 0};
`endif
        vecs[6] = '{16'hC123, 2'd1, 4'h0, 0, 8'h00, 27'h0020000, 16'd1, 1, 0, 8'hFF, 6'h13, 1, 27'h0020123, 0, 0};
        vecs[7] = '{16'h8001, 2'd0, 4'h0, 0, 8'h00, 27'h1234567, 16'd0, 1, 0, 8'hFF, 6'h02, 1, 27'h1234567, 0, 0};
        vecs[8] = '{16'h4000, 2'd0, 4'h0, 0, 8'h00, 27'h7FFC000, 16'd2, 1, 0, 8'hFF, 6'h01, 1, 27'h0000000, 0, 0};

        reset_n         = 1'b0;
        mem_bus.mem_ack = 1'b0;
        drive(16'h0000, 2'd0, 4'h0, 0, 8'h00, 27'h0, 16'd0, 0, 0);
        release_bus();
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_bus.mem_we), 32'd0);
        chk("rst mem_addr", 32'(mem_bus.mem_addr), 32'd0);
        chk("rst mem_din", 32'(mem_bus.mem_din), 32'd0);
        chk("rst wait_n", 32'(wait_n), 32'd1);
        chk("rst unmapped", 32'(unmapped), 32'd0);
        chk("rst layout_idx", 32'(layout_idx), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
        end

        // Re-strobe during HOLD with mreq held, plus a stray ack: both ignored.
        next_cycle();
        drive(16'h2000, 2'd0, 4'h0, 0, 8'h00, 27'h0, 16'd2, 0, 0);
        next_cycle();
        next_cycle();
        next_cycle();
        cpu_rd = 1'b0;
        next_cycle();
        cpu_rd          = 1'b1;
        mem_bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("hold restrobe wait_n", 32'(wait_n), 32'd1);
        next_cycle();
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("hold restrobe mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("hold restrobe wait_n2", 32'(wait_n), 32'd1);
        chk("hold restrobe unmapped", 32'(unmapped), 32'd1);
        release_bus();
        next_cycle();

        // Reset in the middle of ACCESS.
        next_cycle();
        drive(16'h8000, 2'd3, 4'h8, 0, 8'h00, 27'h0, 16'd4, 1, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("mid rst pre mem_req", 32'(mem_bus.mem_req), 32'd1);
        reset_n = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("mid rst mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("mid rst wait_n", 32'(wait_n), 32'd1);
        next_cycle();
        reset_n = 1'b1;
        release_bus();
        next_cycle();
        next_cycle();
        drive(16'hFFFF, 2'd3, 4'h8, 0, 8'h00, 27'h0, 16'd4, 1, 0);
        @(negedge clk);
        chk("mid rst sub cleared", 32'(exp_dout), 32'hFF);
        next_cycle();
        next_cycle();
        next_cycle();
        release_bus();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
